// File: rtl/imem_pkg.sv
// -----------------------------------------------------------------------------
// imem_pkg
// Shared types and constants for the loadable instruction memory.
//   imem_state_e   : controller states (empty / loading / running)
//   NOP_INSTR      : word returned whenever no real instruction is presented
//   *_DEF          : default geometry used by imem_loadable
// -----------------------------------------------------------------------------
package imem_pkg;

   localparam int unsigned DEPTH_LOG2_DEF = 8;
   localparam int unsigned DATA_W_DEF     = 32;
   localparam int unsigned ADDR_W_DEF     = 32;

   localparam logic [DATA_W_DEF-1:0] NOP_INSTR = '0;

   typedef enum logic [1:0] {
      StEmpty = 2'd0,
      StLoad  = 2'd1,
      StRun   = 2'd2
   } imem_state_e;

endpackage

// File: rtl/imem_ram.sv
// -----------------------------------------------------------------------------
// imem_ram
// Instruction storage: one write port, one synchronous read port, no reset on
// the array or the read register.
//   clk    in  : clock
//   we     in  : write enable, writes wdata to mem[waddr] at the rising edge
//   waddr  in  : write word index
//   wdata  in  : write data
//   re     in  : read enable; when low rdata holds its previous value
//   raddr  in  : read word index
//   rdata  out : registered read data
// -----------------------------------------------------------------------------
module imem_ram #(
   parameter int unsigned DEPTH_LOG2 = 8,
   parameter int unsigned DATA_W     = 32
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [DEPTH_LOG2-1:0] waddr,
   input  logic [DATA_W-1:0]     wdata,
   input  logic                  re,
   input  logic [DEPTH_LOG2-1:0] raddr,
   output logic [DATA_W-1:0]     rdata
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/imem_loadable.sv
// -----------------------------------------------------------------------------
// imem_loadable
// Run-time loadable instruction memory with a registered fetch port.
// A program is streamed in over a valid/ready channel; fetches then return one
// word per cycle with one cycle of latency, with stall/flush and fault flags.
//   clk, rst_n    in  : clock, asynchronous active-low reset
//   load_start    in  : restart loading at word 0 (any state)
//   load_valid    in  : load beat valid
//   load_data     in  : instruction word for the current beat
//   load_last     in  : final beat of the program
//   load_ready    out : accepting load beats (LOAD state)
//   fetch_addr    in  : byte address from the PC
//   fetch_stall   in  : hold fetch outputs
//   fetch_flush   in  : next output is a NOP bubble
//   instr         out : fetched instruction
//   instr_valid   out : instr is a real fetch result
//   addr_fault    out : fetch address misaligned or out of range
//   running       out : RUN state
// -----------------------------------------------------------------------------
module imem_loadable
   import imem_pkg::*;
#(
   parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEF,
   parameter int unsigned DATA_W     = DATA_W_DEF,
   parameter int unsigned ADDR_W     = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_start,
   input  logic              load_valid,
   input  logic [DATA_W-1:0] load_data,
   input  logic              load_last,
   output logic              load_ready,
   input  logic [ADDR_W-1:0] fetch_addr,
   input  logic              fetch_stall,
   input  logic              fetch_flush,
   output logic [DATA_W-1:0] instr,
   output logic              instr_valid,
   output logic              addr_fault,
   output logic              running
);

   localparam logic [DEPTH_LOG2-1:0] PTR_MAX = '1;

   imem_state_e           state_q;
   logic [DEPTH_LOG2-1:0] ptr_q;
   logic                  load_ready_q;
   logic                  running_q;

   logic                  beat;
   logic                  beat_final;
   logic [DEPTH_LOG2-1:0] word_idx;
   logic                  fault;
   logic                  fetch_take;
   logic [DATA_W-1:0]     ram_rdata;

   logic                  instr_valid_q;
   logic                  addr_fault_q;
   logic                  show_q;

   // load_start wins over a same-cycle beat, so the beat is dropped.
   assign beat       = load_valid & (state_q == StLoad) & ~load_start;
   // Filling the last word ends the load even without load_last.
   assign beat_final = load_last | (ptr_q == PTR_MAX);

   // Controller: state, write pointer and registered state decodes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StEmpty;
         ptr_q        <= '0;
         load_ready_q <= 1'b0;
         running_q    <= 1'b0;
      end else if (load_start) begin
         state_q      <= StLoad;
         ptr_q        <= '0;
         load_ready_q <= 1'b1;
         running_q    <= 1'b0;
      end else if (beat) begin
         // Pointer saturates at the top word; no wrap.
         if (ptr_q != PTR_MAX) begin
            ptr_q <= ptr_q + DEPTH_LOG2'(1);
         end
         if (beat_final) begin
            state_q      <= StRun;
            load_ready_q <= 1'b0;
            running_q    <= 1'b1;
         end
      end
   end

   assign word_idx = fetch_addr[DEPTH_LOG2+1:2];
   assign fault    = (fetch_addr[1:0] != 2'b00) || ((fetch_addr >> (DEPTH_LOG2 + 2)) != '0);

   // The RAM read register doubles as the instr data register; a stall simply
   // withholds the read enable so the previous word is kept.
   assign fetch_take = (state_q == StRun) & ~fetch_flush & ~fetch_stall;

   imem_ram #(
      .DEPTH_LOG2(DEPTH_LOG2),
      .DATA_W    (DATA_W)
   ) u_ram (
      .clk  (clk),
      .we   (beat),
      .waddr(ptr_q),
      .wdata(load_data),
      .re   (fetch_take),
      .raddr(word_idx),
      .rdata(ram_rdata)
   );

   // Output flags; show_q selects RAM data versus NOP for instr.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr_valid_q <= 1'b0;
         addr_fault_q  <= 1'b0;
         show_q        <= 1'b0;
      end else if ((state_q != StRun) || fetch_flush) begin
         instr_valid_q <= 1'b0;
         addr_fault_q  <= 1'b0;
         show_q        <= 1'b0;
      end else if (!fetch_stall) begin
         instr_valid_q <= 1'b1;
         addr_fault_q  <= fault;
         show_q        <= ~fault;
      end
   end

   assign instr       = show_q ? ram_rdata : DATA_W'(NOP_INSTR);
   assign instr_valid = instr_valid_q;
   assign addr_fault  = addr_fault_q;
   assign load_ready  = load_ready_q;
   assign running     = running_q;

endmodule

// File: tb/tb_imem_loadable.sv
// -----------------------------------------------------------------------------
// tb_imem_loadable
// Directed stimulus against imem_loadable with a behavioural reference model
// checked every cycle, plus hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_imem_loadable;

   localparam int DEPTH_LOG2 = 8;
   localparam int DATA_W     = 32;
   localparam int ADDR_W     = 32;
   localparam int DEPTH      = 1 << DEPTH_LOG2;

   logic              clk         = 1'b0;
   logic              rst_n       = 1'b0;
   logic              load_start  = 1'b0;
   logic              load_valid  = 1'b0;
   logic [DATA_W-1:0] load_data   = '0;
   logic              load_last   = 1'b0;
   logic              load_ready;
   logic [ADDR_W-1:0] fetch_addr  = '0;
   logic              fetch_stall = 1'b0;
   logic              fetch_flush = 1'b0;
   logic [DATA_W-1:0] instr;
   logic              instr_valid;
   logic              addr_fault;
   logic              running;

   always #5 clk = ~clk;

   imem_loadable #(
      .DEPTH_LOG2(DEPTH_LOG2),
      .DATA_W    (DATA_W),
      .ADDR_W    (ADDR_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_start (load_start),
      .load_valid (load_valid),
      .load_data  (load_data),
      .load_last  (load_last),
      .load_ready (load_ready),
      .fetch_addr (fetch_addr),
      .fetch_stall(fetch_stall),
      .fetch_flush(fetch_flush),
      .instr      (instr),
      .instr_valid(instr_valid),
      .addr_fault (addr_fault),
      .running    (running)
   );

   // Reference model: mode 0 = empty, 1 = loading, 2 = running.
   logic [DATA_W-1:0] m_mem [DEPTH];
   int                m_mode  = 0;
   int                m_ptr   = 0;
   logic [DATA_W-1:0] e_instr = '0;
   logic              e_valid = 1'b0;
   logic              e_fault = 1'b0;

   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         m_mode  = 0;
         m_ptr   = 0;
         e_instr = '0;
         e_valid = 1'b0;
         e_fault = 1'b0;
      end else begin
         if (m_mode == 2 && fetch_flush) begin
            e_instr = '0;
            e_valid = 1'b0;
            e_fault = 1'b0;
         end else if (m_mode == 2 && !fetch_stall) begin
            if ((fetch_addr % 4) != 0 || fetch_addr >= 4 * DEPTH) begin
               e_instr = '0;
               e_valid = 1'b1;
               e_fault = 1'b1;
            end else begin
               e_instr = m_mem[fetch_addr / 4];
               e_valid = 1'b1;
               e_fault = 1'b0;
            end
         end else if (m_mode != 2) begin
            e_instr = '0;
            e_valid = 1'b0;
            e_fault = 1'b0;
         end
         if (load_start) begin
            m_mode = 1;
            m_ptr  = 0;
         end else if (m_mode == 1 && load_valid) begin
            m_mem[m_ptr] = load_data;
            if (load_last || m_ptr == DEPTH - 1) m_mode = 2;
            m_ptr = m_ptr + 1;
         end
      end
   end

   int n_vec  = 0;
   int n_err  = 0;
   bit cmp_en = 1'b0;

   initial forever begin
      @(negedge clk);
      if (cmp_en) begin
         n_vec++;
         if ({instr, instr_valid, addr_fault, load_ready, running} !==
             {e_instr, e_valid, e_fault, (m_mode == 1), (m_mode == 2)}) begin
            n_err++;
            $display("FAIL model t=%0t: got instr=%h v=%b f=%b rdy=%b run=%b, want instr=%h v=%b f=%b rdy=%b run=%b",
                     $time, instr, instr_valid, addr_fault, load_ready, running,
                     e_instr, e_valid, e_fault, (m_mode == 1), (m_mode == 2));
         end
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %h, want %h", name, got, want);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic start_load();
      load_start = 1'b1;
      step();
      load_start = 1'b0;
   endtask

   task automatic beat(input logic [31:0] d, input logic last);
      load_valid = 1'b1;
      load_data  = d;
      load_last  = last;
      step();
      load_valid = 1'b0;
      load_last  = 1'b0;
   endtask

   initial begin
      repeat (2) step();
      rst_n  = 1'b1;
      cmp_en = 1'b1;

      // Empty: fetches return NOP.
      fetch_addr = 32'h0;
      step();
      check("empty instr", instr, 32'h0);
      check("empty valid", {31'b0, instr_valid}, 32'h0);
      check("empty running", {31'b0, running}, 32'h0);
      check("empty ready", {31'b0, load_ready}, 32'h0);

      // Three-beat program.
      start_load();
      check("load ready", {31'b0, load_ready}, 32'h1);
      beat(32'h2004_0001, 1'b0);
      beat(32'h2005_0002, 1'b0);
      beat(32'h0085_3020, 1'b1);
      check("run after last", {31'b0, running}, 32'h1);
      check("ready after last", {31'b0, load_ready}, 32'h0);

      fetch_addr = 32'h0;
      step();
      check("fetch 0x0", instr, 32'h2004_0001);
      check("fetch 0x0 valid", {31'b0, instr_valid}, 32'h1);
      fetch_addr = 32'h4;
      step();
      check("fetch 0x4", instr, 32'h2005_0002);
      fetch_addr = 32'h8;
      step();
      check("fetch 0x8", instr, 32'h0085_3020);

      // Faults.
      fetch_addr = 32'h2;
      step();
      check("misaligned instr", instr, 32'h0);
      check("misaligned fault", {31'b0, addr_fault}, 32'h1);
      check("misaligned valid", {31'b0, instr_valid}, 32'h1);
      fetch_addr = 32'h400;
      step();
      check("range instr", instr, 32'h0);
      check("range fault", {31'b0, addr_fault}, 32'h1);

      // Stall holds, flush beats stall.
      fetch_addr = 32'h4;
      step();
      check("pre-stall", instr, 32'h2005_0002);
      check("pre-stall fault", {31'b0, addr_fault}, 32'h0);
      fetch_stall = 1'b1;
      fetch_addr  = 32'h8;
      step();
      check("stall 1", instr, 32'h2005_0002);
      step();
      check("stall 2", instr, 32'h2005_0002);
      fetch_flush = 1'b1;
      step();
      check("flush instr", instr, 32'h0);
      check("flush valid", {31'b0, instr_valid}, 32'h0);
      fetch_stall = 1'b0;
      fetch_flush = 1'b0;
      step();
      check("post-flush", instr, 32'h0085_3020);

      // Full-depth load without load_last, then a refused extra beat.
      start_load();
      for (int i = 0; i < DEPTH; i++) begin
         beat(32'hA000_0000 + 32'(i), 1'b0);
      end
      check("full run", {31'b0, running}, 32'h1);
      check("full ready", {31'b0, load_ready}, 32'h0);
      beat(32'hDEAD_BEEF, 1'b1);
      fetch_addr = 32'h0;
      step();
      check("word 0 kept", instr, 32'hA000_0000);
      fetch_addr = 32'h3FC;
      step();
      check("word 255", instr, 32'hA000_00FF);
      fetch_addr = 32'h80;
      step();
      check("word 32", instr, 32'hA000_0020);

      // Reset during the second beat of a load.
      start_load();
      beat(32'h1111_1111, 1'b0);
      load_valid = 1'b1;
      load_data  = 32'h2222_2222;
      #2 rst_n = 1'b0;
      #1;
      check("mid-reset ready", {31'b0, load_ready}, 32'h0);
      check("mid-reset running", {31'b0, running}, 32'h0);
      step();
      load_valid = 1'b0;
      rst_n      = 1'b1;
      step();
      start_load();
      beat(32'h1234_5678, 1'b1);
      check("reload running", {31'b0, running}, 32'h1);
      fetch_addr = 32'h0;
      step();
      check("reload word 0", instr, 32'h1234_5678);
      check("reload valid", {31'b0, instr_valid}, 32'h1);

      step();
      cmp_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/imem_loadable.md
# imem_loadable

Parametrised, synchronous instruction memory for the pipelined CPU with a streaming program-load port. It replaces a fixed-contents combinational ROM: the program is written at run time through a valid/ready load channel, and fetches are served through a registered read port with stall, flush and fault signalling. It sits between the IF-stage PC register and the IF/ID pipeline register.

## Interface
- `DEPTH_LOG2`, default 8: memory holds 2^DEPTH_LOG2 words.
- `DATA_W`, default 32: instruction width.
- `ADDR_W`, default 32: byte-address width of `fetch_addr`.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `load_start`  in  1  begin a new program load; pulse, sampled every cycle.
- `load_valid`  in  1  load beat valid.
- `load_data`  in  DATA_W  instruction word to write.
- `load_last`  in  1  marks the final beat of a load.
- `load_ready`  out  1  high only in LOAD state.
- `fetch_addr`  in  ADDR_W  byte address from the PC.
- `fetch_stall`  in  1  hold current output.
- `fetch_flush`  in  1  replace next output with NOP.
- `instr`  out  DATA_W  fetched instruction.
- `instr_valid`  out  1  `instr` holds a real fetched word.
- `addr_fault`  out  1  `instr` came from a misaligned or out-of-range address.
- `running`  out  1  high in RUN state.

## Operation
- FSM states: EMPTY (reset), LOAD, RUN.
- EMPTY: `load_ready`=0, fetch output forced to NOP, `instr_valid`=0.
- `load_start` in any state: go to LOAD and set the write pointer to 0. Contents beyond the new program are stale but are never cleared.
- LOAD: `load_ready`=1. Each beat with `load_valid`&`load_ready` writes `mem[ptr]` and increments `ptr`. A beat with `load_last`=1 goes to RUN. A beat at `ptr`=DEPTH-1 also goes to RUN even without `load_last`: the pointer does not wrap and further data is refused. While in LOAD, fetch outputs NOP with `instr_valid`=0.
- `load_start` has priority over a same-cycle beat: that beat is not written and the pointer restarts at 0.
- RUN: word index = `fetch_addr[DEPTH_LOG2+1:2]`.
  - Fault if `fetch_addr[1:0]`≠0 or any bit of `fetch_addr[ADDR_W-1:DEPTH_LOG2+2]` is set. A faulting fetch returns `instr`=NOP, `instr_valid`=1, `addr_fault`=1.
- Output-register priority: reset > flush > stall > normal fetch.
  - Flush: NOP, `instr_valid`=0, `addr_fault`=0.
  - Stall: all three outputs hold their values.
- NOP = all zeros.

## Timing
- Reset values: `instr`=0, `instr_valid`=0, `addr_fault`=0, `load_ready`=0, `running`=0, state EMPTY, `ptr`=0.
- Fetch latency is 1 cycle: the `fetch_addr` present at edge N appears on `instr` after edge N. Back-to-back fetches give one word per cycle.
- A load write takes effect at its edge. The first RUN fetch can occur on the cycle after the last-beat edge and returns the newly written data.
- `load_ready` and `running` are registered decodes of the state.
- Reset asserted mid-load: FSM returns to EMPTY and memory contents are undefined; a full reload is required.
- `fetch_stall` and `fetch_flush` are ignored outside RUN.

## Structure
- Package `imem_pkg`:
  - state enum (EMPTY/LOAD/RUN);
  - `NOP_INSTR` constant;
  - default width constants.
- Sub-module `imem_ram`: single write port, one synchronous read port, parametrised by `DEPTH_LOG2` and `DATA_W`, no reset on the array.
- Top level contains the FSM, write pointer, fault decode and output register.

## Test plan
- Reset release, then fetch 0x0 → `instr`=0, `instr_valid`=0, `running`=0 until a load completes.
- Load 3 beats 0x20040001, 0x20050002, 0x00853020 (last on beat 3), then fetch 0x0/0x4/0x8 on consecutive cycles → those words on consecutive cycles, `instr_valid`=1.
- In RUN, fetch 0x2 → NOP with `addr_fault`=1. Fetch 0x400 with DEPTH_LOG2=8 → NOP with `addr_fault`=1.
- Fetch 0x4, then assert `fetch_stall` for 2 cycles while the address changes to 0x8 → `instr` stays 0x20050002. Assert stall and flush together → NOP with `instr_valid`=0.
- Load 256 beats without `load_last` → state is RUN after beat 256, `load_ready`=0, and a 257th beat is not written (word 0 unchanged).
- `rst_n` low during beat 2 of a load → `load_ready`=0 and `running`=0 at once. After release, a new 1-beat load with `load_last` completes normally.
